// File: rtl/w25q_cmd_seq_if.sv
// Byte-level handshake between the W25Q command sequencer and the SPI master
// (spi_ctrl). The sequencer is the master: it presents a byte and a one-cycle
// trigger, and the SPI master answers with swap_done and the received byte.
interface w25q_cmd_seq_if;
    logic [7:0] write_byte;
    logic       swap_trigger;
    logic       swap_done;
    logic [7:0] read_byte;

    modport master (
        output write_byte,
        output swap_trigger,
        input  swap_done,
        input  read_byte
    );

    modport slave (
        input  write_byte,
        input  swap_trigger,
        output swap_done,
        output read_byte
    );
endinterface

// File: rtl/w25q_cmd_seq.sv
// W25Q128 command sequencer. It owns chip-select and turns one read or
// page-program request into the flash byte sequence, one byte at a time over
// the spi_ctrl handshake. A program runs as WREN, then PAGE PROGRAM, then a
// status poll that repeats until the BUSY bit clears.
// Optional build macro: W25Q_POLL_TIMEOUT_EN bounds the status poll to
// POLL_MAX bytes and flags a timeout on err together with done.
module w25q_cmd_seq #(
    parameter int MAX_LEN  = 256,
    parameter int CS_SETUP = 3,
    parameter int CS_GAP   = 3,
    parameter int POLL_MAX = 50000
) (
    input  logic          sclk,
    input  logic          rst,
    input  logic          op_start,
    input  logic          op_code,
    input  logic [23:0]   addr,
    input  logic [8:0]    len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    input  logic [7:0]    wr_data,
    output logic          wr_req,
    output logic          cs,
    w25q_cmd_seq_if.master spi
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CS_LOW  = 3'd1;
    localparam logic [2:0] S_XFER    = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_NEXT    = 3'd4;
    localparam logic [2:0] S_CS_HIGH = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    // Which transaction of the operation is running.
    localparam logic [1:0] PH_READ = 2'd0;
    localparam logic [1:0] PH_WREN = 2'd1;
    localparam logic [1:0] PH_PROG = 2'd2;
    localparam logic [1:0] PH_POLL = 2'd3;

    // Which part of the transaction the current byte belongs to.
    localparam logic [1:0] SUB_CMD  = 2'd0;
    localparam logic [1:0] SUB_ADDR = 2'd1;
    localparam logic [1:0] SUB_DATA = 2'd2;

    logic [2:0]  state;
    logic [1:0]  phase;
    logic [1:0]  sub;
    logic [2:0]  aidx;
    logic [8:0]  bcnt;
    logic [8:0]  len_q;
    logic [23:0] addr_q;
    logic [7:0]  tcnt;
    logic        poll_clear;
    logic [7:0]  tx_byte;
    logic [8:0]  len_clamp;
    logic        poll_to;
    logic        poll_limit;

`ifdef W25Q_POLL_TIMEOUT_EN
    localparam int PW = $clog2(POLL_MAX + 1);
    logic [PW-1:0] poll_cnt;
    assign poll_limit = (poll_cnt == PW'(POLL_MAX));
`else
    // Unbounded polling: the limit can never be reached and err stays low.
    assign poll_to    = 1'b0;
    assign poll_limit = (POLL_MAX < 0);
`endif

    assign len_clamp = (len > 9'(MAX_LEN)) ? 9'(MAX_LEN) : len;

    // Byte to present on the next trigger, chosen by transaction and position.
    always_comb begin
        tx_byte = 8'h00;
        case (sub)
            SUB_CMD: begin
                case (phase)
                    PH_READ: tx_byte = 8'h03;
                    PH_WREN: tx_byte = 8'h06;
                    PH_PROG: tx_byte = 8'h02;
                    default: tx_byte = 8'h05;
                endcase
            end
            SUB_ADDR: begin
                case (aidx)
                    3'd0:    tx_byte = addr_q[23:16];
                    3'd1:    tx_byte = addr_q[15:8];
                    default: tx_byte = addr_q[7:0];
                endcase
            end
            default: tx_byte = (phase == PH_PROG) ? wr_data : 8'h00;
        endcase
    end

    // Sequencer FSM: chip-select timing, byte handshake and transaction chaining.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state            <= S_IDLE;
            cs               <= 1'b1;
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
            rd_valid         <= 1'b0;
            rd_data          <= 8'h00;
            wr_req           <= 1'b0;
            spi.swap_trigger <= 1'b0;
            spi.write_byte   <= 8'h00;
            phase            <= PH_READ;
            sub              <= SUB_CMD;
            aidx             <= 3'd0;
            bcnt             <= 9'd0;
            len_q            <= 9'd0;
            addr_q           <= 24'h0;
            tcnt             <= 8'd0;
            poll_clear       <= 1'b0;
`ifdef W25Q_POLL_TIMEOUT_EN
            poll_cnt         <= '0;
            poll_to          <= 1'b0;
`endif
        end else begin
            done             <= 1'b0;
            err              <= 1'b0;
            rd_valid         <= 1'b0;
            wr_req           <= 1'b0;
            spi.swap_trigger <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (op_start && (len != 9'd0)) begin
                        busy   <= 1'b1;
                        cs     <= 1'b0;
                        tcnt   <= 8'd0;
                        addr_q <= addr;
                        len_q  <= len_clamp;
                        phase  <= op_code ? PH_WREN : PH_READ;
                        sub    <= SUB_CMD;
                        state  <= S_CS_LOW;
`ifdef W25Q_POLL_TIMEOUT_EN
                        poll_to <= 1'b0;
`endif
                    end
                end
                S_CS_LOW: begin
                    if (tcnt == 8'(CS_SETUP - 1)) state <= S_XFER;
                    else tcnt <= tcnt + 8'd1;
                end
                S_XFER: begin
                    spi.write_byte   <= tx_byte;
                    spi.swap_trigger <= 1'b1;
                    state            <= S_WAIT;
                end
                S_WAIT: begin
                    if (spi.swap_done) begin
                        state <= S_NEXT;
                        if (sub == SUB_DATA && phase == PH_READ) begin
                            rd_data  <= spi.read_byte;
                            rd_valid <= 1'b1;
                        end
                        if (sub == SUB_DATA && phase == PH_POLL) begin
                            poll_clear <= ~spi.read_byte[0];
`ifdef W25Q_POLL_TIMEOUT_EN
                            poll_cnt <= poll_cnt + 1'b1;
`endif
                        end
                    end
                end
                S_NEXT: begin
                    case (sub)
                        SUB_CMD: begin
                            if (phase == PH_WREN) begin
                                cs    <= 1'b1;
                                tcnt  <= 8'd0;
                                state <= S_CS_HIGH;
                            end else if (phase == PH_POLL) begin
                                sub   <= SUB_DATA;
                                state <= S_XFER;
                            end else begin
                                sub   <= SUB_ADDR;
                                aidx  <= 3'd0;
                                state <= S_XFER;
                            end
                        end
                        SUB_ADDR: begin
                            if (aidx == 3'd2) begin
                                sub    <= SUB_DATA;
                                bcnt   <= 9'd0;
                                wr_req <= (phase == PH_PROG);
                            end else begin
                                aidx <= aidx + 3'd1;
                            end
                            state <= S_XFER;
                        end
                        default: begin
                            if (phase == PH_POLL) begin
                                if (poll_clear || poll_limit) begin
                                    cs    <= 1'b1;
                                    tcnt  <= 8'd0;
                                    state <= S_CS_HIGH;
`ifdef W25Q_POLL_TIMEOUT_EN
                                    poll_to <= ~poll_clear;
`endif
                                end else begin
                                    state <= S_XFER;
                                end
                            end else if (bcnt == len_q - 9'd1) begin
                                cs    <= 1'b1;
                                tcnt  <= 8'd0;
                                state <= S_CS_HIGH;
                            end else begin
                                bcnt   <= bcnt + 9'd1;
                                wr_req <= (phase == PH_PROG);
                                state  <= S_XFER;
                            end
                        end
                    endcase
                end
                S_CS_HIGH: begin
                    if (tcnt == 8'(CS_GAP - 1)) begin
                        tcnt <= 8'd0;
                        if (phase == PH_WREN) begin
                            phase <= PH_PROG;
                            sub   <= SUB_CMD;
                            cs    <= 1'b0;
                            state <= S_CS_LOW;
                        end else if (phase == PH_PROG) begin
                            phase      <= PH_POLL;
                            sub        <= SUB_CMD;
                            poll_clear <= 1'b0;
                            cs         <= 1'b0;
                            state      <= S_CS_LOW;
`ifdef W25Q_POLL_TIMEOUT_EN
                            poll_cnt <= '0;
`endif
                        end else begin
                            done  <= 1'b1;
                            err   <= poll_to;
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_w25q_cmd_seq.sv
// Testbench for w25q_cmd_seq: a behavioural spi_ctrl/flash responder with
// random swap latency, bus monitors, and an expected-sequence model built
// from the flash command rules.
`timescale 1ns/1ps
module tb_w25q_cmd_seq;
`ifdef W25Q_POLL_TIMEOUT_EN
    localparam int PMAX = 4;
`else
    localparam int PMAX = 50000;
`endif

    logic        sclk = 1'b0;
    logic        rst = 1'b1;
    logic        op_start = 1'b0;
    logic        op_code = 1'b0;
    logic [23:0] addr = 24'h0;
    logic [8:0]  len = 9'd0;
    logic [7:0]  wr_data = 8'h00;
    logic        busy, done, err, rd_valid, wr_req, cs;
    logic [7:0]  rd_data;

    w25q_cmd_seq_if bus ();

    w25q_cmd_seq #(.MAX_LEN(256), .CS_SETUP(3), .CS_GAP(3), .POLL_MAX(PMAX)) dut (
        .sclk(sclk), .rst(rst), .op_start(op_start), .op_code(op_code),
        .addr(addr), .len(len), .busy(busy), .done(done), .err(err),
        .rd_data(rd_data), .rd_valid(rd_valid), .wr_data(wr_data),
        .wr_req(wr_req), .cs(cs), .spi(bus)
    );

    always #5 sclk = ~sclk;

    int checks = 0;
    int errors = 0;

    // Flash-side content
    logic [7:0] rd_src [256];
    logic [7:0] wr_src [256];
    logic [7:0] stat [8];
    int         stat_n = 0;
    bit         stat_stuck = 0;

    // Captured activity
    logic [7:0] mosi_q [$];
    int         wlen_q [$];
    logic [7:0] rdq [$];
    int cur_n = 0, wr_idx = 0, wreq_cnt = 0, done_cnt = 0, err_cnt = 0;
    int err_nodone = 0, done_busy_bad = 0, stab_err = 0, dbl_err = 0;
    int min_setup = 1000, min_gap = 1000, low_cnt = 0, high_cnt = 1000;
    bit first_trig = 0, prev_cs = 1, seen_window = 0, pend = 0;
    int dly = 0;
    logic [7:0] held = 8'h00, kind = 8'h00, resp = 8'h00;

    // Expected activity
    logic [7:0] emosi [$];
    int         ewlen [$];
    logic [7:0] erd [$];

    // spi_ctrl responder and bus monitors, sampled on the falling edge
    always @(negedge sclk) begin
        if (rst) begin
            pend = 0;
            bus.swap_done = 1'b0;
            bus.read_byte = 8'h00;
            cur_n = 0;
            prev_cs = 1'b1;
        end else begin
            bus.swap_done = 1'b0;
            if (prev_cs && !cs) begin
                if (seen_window && high_cnt < min_gap) min_gap = high_cnt;
                cur_n = 0;
                low_cnt = 0;
                first_trig = 0;
            end
            if (!prev_cs && cs) begin
                wlen_q.push_back(cur_n);
                seen_window = 1;
                high_cnt = 0;
            end
            if (cs) high_cnt++;
            if (!cs && !first_trig) begin
                if (bus.swap_trigger) begin
                    if (low_cnt < min_setup) min_setup = low_cnt;
                    first_trig = 1;
                end else begin
                    low_cnt++;
                end
            end
            if (pend) begin
                if (bus.write_byte !== held) stab_err++;
                if (bus.swap_trigger) dbl_err++;
                if (dly == 0) begin
                    bus.swap_done = 1'b1;
                    bus.read_byte = resp;
                    pend = 0;
                end else begin
                    dly--;
                end
            end else if (bus.swap_trigger) begin
                held = bus.write_byte;
                pend = 1;
                dly = int'($urandom_range(3, 0));
                if (cur_n == 0) kind = held;
                if (kind == 8'h03 && cur_n >= 4 && cur_n < 260) resp = rd_src[cur_n - 4];
                else if (kind == 8'h05 && cur_n >= 1)
                    resp = stat_stuck ? 8'h01 : ((cur_n - 1 < stat_n) ? stat[cur_n - 1] : 8'h00);
                else resp = 8'($urandom);
                mosi_q.push_back(held);
                cur_n++;
            end
            if (rd_valid) rdq.push_back(rd_data);
            if (wr_req) begin
                wreq_cnt++;
                wr_data = wr_src[wr_idx % 256];
                wr_idx++;
            end
            if (done) begin
                done_cnt++;
                if (busy !== 1'b0) done_busy_bad++;
                if (err) err_cnt++;
            end else if (err) begin
                err_nodone++;
            end
            prev_cs = cs;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_capture();
        mosi_q.delete(); wlen_q.delete(); rdq.delete();
        emosi.delete(); ewlen.delete(); erd.delete();
        wr_idx = 0; wreq_cnt = 0; done_cnt = 0; err_cnt = 0; err_nodone = 0;
        done_busy_bad = 0; stab_err = 0; dbl_err = 0;
        min_setup = 1000; min_gap = 1000;
    endtask

    task automatic push_hdr(input logic [7:0] cmd, input logic [23:0] a);
        emosi.push_back(cmd);
        emosi.push_back(a[23:16]);
        emosi.push_back(a[15:8]);
        emosi.push_back(a[7:0]);
    endtask

    function automatic int clamp(input int l);
        return (l > 256) ? 256 : l;
    endfunction

    task automatic exp_read(input logic [23:0] a, input int l);
        int n = clamp(l);
        push_hdr(8'h03, a);
        for (int i = 0; i < n; i++) begin
            emosi.push_back(8'h00);
            erd.push_back(rd_src[i]);
        end
        ewlen.push_back(4 + n);
    endtask

    task automatic exp_prog(input logic [23:0] a, input int l);
        int n = clamp(l);
        int k = 0;
        emosi.push_back(8'h06);
        ewlen.push_back(1);
        push_hdr(8'h02, a);
        for (int i = 0; i < n; i++) emosi.push_back(wr_src[i]);
        ewlen.push_back(4 + n);
        if (stat_stuck) k = PMAX;
        else begin
            while (k < stat_n && stat[k][0]) k++;
            k = k + 1;
        end
        emosi.push_back(8'h05);
        for (int i = 0; i < k; i++) emosi.push_back(8'h00);
        ewlen.push_back(1 + k);
    endtask

    task automatic start_op(input logic op, input logic [23:0] a, input logic [8:0] l);
        @(negedge sclk);
        op_start = 1'b1; op_code = op; addr = a; len = l;
        @(negedge sclk);
        op_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        while (done_cnt == 0 && n < max) begin
            @(negedge sclk);
            n++;
        end
        chk({tag, "_timeout"}, 32'(done_cnt == 0), 32'd0);
        repeat (12) @(negedge sclk);
    endtask

    task automatic check_result(input string tag, input int exp_wreq, input int exp_err);
        int mism = 0;
        chk({tag, "_windows"}, wlen_q.size(), ewlen.size());
        for (int i = 0; i < wlen_q.size() && i < ewlen.size(); i++)
            chk({tag, "_winlen"}, wlen_q[i], ewlen[i]);
        chk({tag, "_mosi_len"}, mosi_q.size(), emosi.size());
        for (int i = 0; i < mosi_q.size() && i < emosi.size(); i++)
            if (mosi_q[i] !== emosi[i]) mism++;
        chk({tag, "_mosi_bytes_bad"}, mism, 0);
        mism = 0;
        chk({tag, "_rd_count"}, rdq.size(), erd.size());
        for (int i = 0; i < rdq.size() && i < erd.size(); i++)
            if (rdq[i] !== erd[i]) mism++;
        chk({tag, "_rd_bytes_bad"}, mism, 0);
        chk({tag, "_wr_req"}, wreq_cnt, exp_wreq);
        chk({tag, "_done"}, done_cnt, 1);
        chk({tag, "_err"}, err_cnt, exp_err);
        chk({tag, "_err_alone"}, err_nodone, 0);
        chk({tag, "_busy_at_done"}, done_busy_bad, 0);
        chk({tag, "_cs_setup_ok"}, 32'(min_setup >= 3), 32'd1);
        if (ewlen.size() > 1) chk({tag, "_cs_gap_ok"}, 32'(min_gap >= 3), 32'd1);
        chk({tag, "_wb_stable"}, stab_err, 0);
        chk({tag, "_dbl_trig"}, dbl_err, 0);
    endtask

    task automatic run_read(input string tag, input logic [23:0] a, input int l);
        clear_capture();
        exp_read(a, l);
        start_op(1'b0, a, 9'(l));
        chk({tag, "_busy"}, busy, 1'b1);
        wait_done(tag, 8000);
        check_result(tag, 0, 0);
    endtask

    task automatic run_prog(input string tag, input logic [23:0] a, input int l, input int exp_err);
        clear_capture();
        exp_prog(a, l);
        start_op(1'b1, a, 9'(l));
        chk({tag, "_busy"}, busy, 1'b1);
        wait_done(tag, 8000);
        check_result(tag, clamp(l), exp_err);
    endtask

    task automatic rand_status();
        int nb = int'($urandom_range(2, 0));
        for (int i = 0; i < nb; i++) stat[i] = 8'($urandom) | 8'h01;
        stat[nb] = 8'($urandom) & 8'hFE;
        stat_n = nb + 1;
    endtask

    initial begin
        int n;
        logic [23:0] a;
        for (int i = 0; i < 256; i++) begin
            rd_src[i] = 8'($urandom);
            wr_src[i] = 8'($urandom);
        end

        // Reset state
        repeat (3) @(negedge sclk);
        chk("rst_cs", cs, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_wr_req", wr_req, 1'b0);
        chk("rst_trigger", bus.swap_trigger, 1'b0);
        chk("rst_write_byte", bus.write_byte, 8'h00);
        chk("rst_rd_data", rd_data, 8'h00);
        rst = 1'b0;
        repeat (2) @(negedge sclk);

        // Directed read
        rd_src[0] = 8'hA1; rd_src[1] = 8'hA2; rd_src[2] = 8'hA3; rd_src[3] = 8'hA4;
        run_read("read_dir", 24'h012345, 4);

        // Directed program
        wr_src[0] = 8'h5A; wr_src[1] = 8'hC3;
        stat[0] = 8'h03; stat[1] = 8'h03; stat[2] = 8'h00; stat_n = 3;
        run_prog("prog_dir", 24'h000100, 2, 0);

        // Randomized reads and programs
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 256; i++) rd_src[i] = 8'($urandom);
            run_read("read_rand", 24'($urandom), int'($urandom_range(20, 1)));
        end
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 256; i++) wr_src[i] = 8'($urandom);
            rand_status();
            run_prog("prog_rand", 24'($urandom), int'($urandom_range(12, 1)), 0);
        end

        // len = 0 is ignored
        clear_capture();
        start_op(1'b0, 24'($urandom), 9'd0);
        chk("len0_busy", busy, 1'b0);
        repeat (40) @(negedge sclk);
        chk("len0_cs", cs, 1'b1);
        chk("len0_bytes", mosi_q.size(), 0);
        chk("len0_windows", wlen_q.size(), 0);
        chk("len0_done", done_cnt, 0);

        // len above one page is clamped
        for (int i = 0; i < 256; i++) rd_src[i] = 8'($urandom);
        run_read("read_300", 24'($urandom), 300);

        // Second op_start during a read is ignored
        clear_capture();
        a = 24'($urandom);
        exp_read(a, 8);
        start_op(1'b0, a, 9'd8);
        repeat (20) @(negedge sclk);
        op_start = 1'b1; op_code = 1'b1; addr = ~a; len = 9'd5;
        @(negedge sclk);
        op_start = 1'b0;
        wait_done("read_dup", 8000);
        check_result("read_dup", 0, 0);

        // Reset during the third address byte of PAGE PROGRAM
        clear_capture();
        rand_status();
        start_op(1'b1, 24'($urandom), 9'd3);
        n = 0;
        while (!(wlen_q.size() == 1 && cur_n == 4) && n < 1000) begin
            @(negedge sclk);
            n++;
        end
        chk("rstmid_reached", 32'(n < 1000), 32'd1);
        rst = 1'b1;
        @(negedge sclk);
        chk("rstmid_cs", cs, 1'b1);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_trigger", bus.swap_trigger, 1'b0);
        @(negedge sclk);
        rst = 1'b0;
        repeat (3) @(negedge sclk);
        run_read("read_after_rst", 24'($urandom), int'($urandom_range(6, 1)));

`ifdef W25Q_POLL_TIMEOUT_EN
        // Status stuck busy: poll gives up after POLL_MAX dummies
        stat_stuck = 1;
        run_prog("poll_timeout", 24'($urandom), 1, 1);
        stat_stuck = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
